// File: rtl/counter_updn_param.sv
// Parametrised loadable up/down counter with bounds [MIN, MAX], run-time step,
// wrap/saturate modes, terminal-count pulse and sticky overflow.
// Optional concurrent checks are compiled in when COUNTER_UPDN_ASSERT_EN is defined.
module counter_updn_param #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   MIN     = '0,
    parameter logic [WIDTH-1:0]   MAX     = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]   RST_VAL = MIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_en,
    input  logic             en,
    input  logic             updwn,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] datain,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] dataout,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] SPAN  = MAX - MIN;
    localparam logic [WIDTH:0]   RANGE = {1'b0, SPAN} + {{WIDTH{1'b0}}, 1'b1};

    // Bound tests use the borrow bit of a widened difference, so that default
    // bounds (0 and all-ones) never turn into constant comparisons.
    function automatic logic [WIDTH-1:0] clamp_in(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] below;
        logic [WIDTH:0] above;
        below = {1'b0, v} - {1'b0, MIN};
        above = {1'b0, MAX} - {1'b0, v};
        if (below[WIDTH])
            return MIN;
        else if (above[WIDTH])
            return MAX;
        else
            return v;
    endfunction

    logic [WIDTH:0]   span_diff;
    logic [WIDTH-1:0] s_eff;
    logic [WIDTH-1:0] up_room;
    logic [WIDTH-1:0] dn_room;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_wrap_full;
    logic [WIDTH-1:0] up_wrap;
    logic [WIDTH-1:0] dn_wrap;
    logic [WIDTH-1:0] dn_diff;
    logic             up_evt;
    logic             dn_evt;

    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;

    assign span_diff = {1'b0, SPAN} - {1'b0, step};
    assign s_eff     = span_diff[WIDTH] ? SPAN : step;

    // Distance to each bound; a step larger than the room left is a boundary event.
    assign up_room   = MAX - dataout;
    assign dn_room   = dataout - MIN;
    assign up_evt    = s_eff > up_room;
    assign dn_evt    = s_eff > dn_room;

    assign up_sum       = {1'b0, dataout} + {1'b0, s_eff};
    assign dn_wrap_full = {1'b0, dataout} + RANGE - {1'b0, s_eff};
    assign up_wrap      = WIDTH'(up_sum - RANGE);
    assign dn_wrap      = WIDTH'(dn_wrap_full);
    assign dn_diff      = dataout - s_eff;

    // NOTE: every output of this block is given a default before any branch so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        cnt_nxt = dataout;
        tc_nxt  = 1'b0;
        ovf_nxt = ovf & ~clr_ovf;
        if (ld_en) begin
            cnt_nxt = clamp_in(datain);
        end else if (en) begin
            if (updwn) begin
                if (up_evt) begin
                    cnt_nxt = sat_mode ? MAX : up_wrap;
                    tc_nxt  = 1'b1;
                    ovf_nxt = 1'b1;
                end else begin
                    cnt_nxt = up_sum[WIDTH-1:0];
                end
            end else begin
                if (dn_evt) begin
                    cnt_nxt = sat_mode ? MIN : dn_wrap;
                    tc_nxt  = 1'b1;
                    ovf_nxt = 1'b1;
                end else begin
                    cnt_nxt = dn_diff;
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values and simulation order cannot matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataout <= RST_VAL;
            tc      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            dataout <= cnt_nxt;
            tc      <= tc_nxt;
            ovf     <= ovf_nxt;
        end
    end

`ifdef COUNTER_UPDN_ASSERT_EN
    p_in_range: assert property (@(posedge clk) disable iff (rst)
        dataout == clamp_in(dataout))
        else $error("p_in_range");

    p_load: assert property (@(posedge clk) disable iff (rst)
        ld_en |=> dataout == clamp_in($past(datain)))
        else $error("p_load");

    p_hold: assert property (@(posedge clk) disable iff (rst)
        (!en && !ld_en) |=> $stable(dataout))
        else $error("p_hold");

    p_tc_ovf: assert property (@(posedge clk) disable iff (rst)
        tc |-> ovf)
        else $error("p_tc_ovf");

    p_reset: assert property (@(posedge clk) disable iff (rst)
        rst |=> dataout == RST_VAL)
        else $error("p_reset");
`endif

endmodule

// File: tb/tb_counter_updn_param.sv
// Scoreboard bench for counter_updn_param: directed cases from the test plan,
// then randomized traffic checked against an integer reference model.
module tb_counter_updn_param;

    localparam int LO  = 10;
    localparam int HI  = 200;
    localparam int RV  = 10;
    localparam int RNG = HI - LO + 1;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, ld_en = 1'b0, en = 1'b0, updwn = 1'b0;
    logic       sat_mode = 1'b0, clr_ovf = 1'b0;
    logic [7:0] step = '0, datain = '0;
    logic [7:0] dataout;
    logic       tc, ovf;

    logic       d2_rst = 1'b1, d2_ld = 1'b0, d2_en = 1'b0, d2_up = 1'b0;
    logic [7:0] d2_step = '0, d2_din = '0;
    logic [7:0] d2_dataout;
    logic       d2_tc, d2_ovf;

    counter_updn_param #(
        .WIDTH(8), .MIN(8'd10), .MAX(8'd200), .RST_VAL(8'd10)
    ) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .en(en), .updwn(updwn),
        .sat_mode(sat_mode), .step(step), .datain(datain), .clr_ovf(clr_ovf),
        .dataout(dataout), .tc(tc), .ovf(ovf)
    );

    counter_updn_param dut_dflt (
        .clk(clk), .rst(d2_rst), .ld_en(d2_ld), .en(d2_en), .updwn(d2_up),
        .sat_mode(1'b0), .step(d2_step), .datain(d2_din), .clr_ovf(1'b0),
        .dataout(d2_dataout), .tc(d2_tc), .ovf(d2_ovf)
    );

    typedef struct {
        logic [7:0] q;
        logic       tc;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   m_q;
    bit   m_tc, m_ovf;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: spec rules in plain integer arithmetic.
    task automatic model_update();
        int  s, n, st_i, din_i;
        bit  evt;
        st_i  = int'(step);
        din_i = int'(datain);
        if (rst) begin
            m_q = RV; m_tc = 0; m_ovf = 0;
        end else if (ld_en) begin
            m_q  = (din_i > HI) ? HI : (din_i < LO) ? LO : din_i;
            m_tc = 0;
            if (clr_ovf) m_ovf = 0;
        end else if (en) begin
            s   = (st_i > HI - LO) ? HI - LO : st_i;
            evt = 0;
            if (updwn) begin
                n = m_q + s;
                if (n > HI) begin evt = 1; m_q = sat_mode ? HI : n - RNG; end
                else m_q = n;
            end else begin
                n = m_q - s;
                if (n < LO) begin evt = 1; m_q = sat_mode ? LO : n + RNG; end
                else m_q = n;
            end
            m_tc  = evt;
            m_ovf = evt || (m_ovf && !clr_ovf);
        end else begin
            m_tc = 0;
            if (clr_ovf) m_ovf = 0;
        end
    endtask

    task automatic drive(input bit r, input bit l, input bit e, input bit u, input bit sm,
                         input bit c, input int st, input int din);
        exp_t x;
        @(negedge clk);
        rst = r; ld_en = l; en = e; updwn = u; sat_mode = sm; clr_ovf = c;
        step = 8'(st); datain = 8'(din);
        model_update();
        x.q = 8'(m_q); x.tc = m_tc; x.ovf = m_ovf;
        sb.push_back(x);
    endtask

    task automatic hold();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: the counter presents a result every cycle after each issued stimulus.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("sb_dataout", 32'(dataout), 32'(x.q));
                check("sb_tc",      32'(tc),      32'(x.tc));
                check("sb_ovf",     32'(ovf),     32'(x.ovf));
            end
        end
    end

    initial begin
        // Reset dominates a simultaneous load.
        drive(1, 1, 0, 0, 0, 0, 0, 99);
        drive(1, 1, 0, 0, 0, 0, 0, 99);
        settle();
        check("rst_dataout", 32'(dataout), 32'd10);
        check("rst_tc",      32'(tc),      32'd0);
        check("rst_ovf",     32'(ovf),     32'd0);

        drive(0, 1, 0, 0, 0, 0, 0, 63);
        for (int i = 0; i < 100; i++) drive(0, 0, 1, 1, 0, 0, 1, 0);
        settle();
        check("up100_dataout", 32'(dataout), 32'd163);
        check("up100_ovf",     32'(ovf),     32'd0);

        drive(0, 1, 0, 0, 0, 0, 0, 198);
        drive(0, 0, 1, 1, 0, 0, 5, 0);
        settle();
        check("wrap_up_dataout", 32'(dataout), 32'd12);
        check("wrap_up_tc",      32'(tc),      32'd1);
        check("wrap_up_ovf",     32'(ovf),     32'd1);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        settle();
        check("clr_ovf",     32'(ovf), 32'd0);
        check("clr_tc_low",  32'(tc),  32'd0);

        drive(0, 1, 0, 0, 0, 0, 0, 12);
        drive(0, 0, 1, 0, 1, 0, 5, 0);
        settle();
        check("sat_dn_dataout", 32'(dataout), 32'd10);
        check("sat_dn_tc",      32'(tc),      32'd1);
        drive(0, 0, 1, 0, 1, 0, 5, 0);
        settle();
        check("sat_hold_dataout", 32'(dataout), 32'd10);
        check("sat_hold_tc",      32'(tc),      32'd1);
        drive(0, 1, 0, 0, 0, 0, 0, 12);
        drive(0, 0, 1, 0, 0, 0, 5, 0);
        settle();
        check("wrap_dn_dataout", 32'(dataout), 32'd198);
        check("wrap_dn_tc",      32'(tc),      32'd1);

        drive(0, 1, 0, 0, 0, 0, 0, 255);
        settle();
        check("clamp_hi", 32'(dataout), 32'd200);
        check("load_tc",  32'(tc),      32'd0);
        drive(0, 1, 0, 0, 0, 0, 0, 3);
        settle();
        check("clamp_lo", 32'(dataout), 32'd10);
        drive(0, 1, 1, 1, 0, 0, 7, 50);
        settle();
        check("load_wins", 32'(dataout), 32'd50);
        drive(0, 1, 0, 0, 0, 0, 0, 10);
        drive(0, 0, 1, 1, 0, 0, 250, 0);
        settle();
        check("step_limit_dataout", 32'(dataout), 32'd200);
        check("step_limit_tc",      32'(tc),      32'd0);

        drive(0, 1, 0, 0, 0, 0, 0, 50);
        drive(0, 0, 1, 1, 0, 0, 3, 0);
        drive(0, 0, 1, 1, 0, 0, 3, 0);
        drive(1, 0, 1, 1, 0, 0, 3, 0);
        settle();
        check("midrst_dataout", 32'(dataout), 32'd10);
        check("midrst_ovf",     32'(ovf),     32'd0);
        drive(0, 1, 0, 0, 0, 0, 0, 200);
        drive(0, 0, 1, 1, 0, 1, 1, 0);
        settle();
        check("set_wins_dataout", 32'(dataout), 32'd10);
        check("set_wins_tc",      32'(tc),      32'd1);
        check("set_wins_ovf",     32'(ovf),     32'd1);

        // Default-parameter instance: full 8-bit range wraps 255 -> 0.
        d2_rst = 1'b1;
        hold();
        settle();
        check("dflt_rst", 32'(d2_dataout), 32'd0);
        d2_rst = 1'b0; d2_ld = 1'b1; d2_din = 8'd255;
        hold();
        settle();
        check("dflt_load", 32'(d2_dataout), 32'd255);
        d2_ld = 1'b0; d2_en = 1'b1; d2_up = 1'b1; d2_step = 8'd1;
        hold();
        settle();
        check("dflt_wrap_dataout", 32'(d2_dataout), 32'd0);
        check("dflt_wrap_tc",      32'(d2_tc),      32'd1);
        check("dflt_wrap_ovf",     32'(d2_ovf),     32'd1);
        d2_en = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            int st;
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 8));
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                  st, int'($urandom_range(0, 255)));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_updn_param.md
Name: counter_updn_param

Overview:
- Parametrised successor to the 8-bit loadable up/down counter.
- Adds configurable width and count bounds [MIN, MAX], a run-time step size, and a selectable wrap or saturate mode.
- Outputs a terminal-count pulse and a sticky overflow flag.
- Used as a generic event/address counter inside datapath blocks; drop-in for the fixed 8-bit counter when WIDTH=8, MIN=0, MAX=255, step=1, wrap mode.

Parameters:
- WIDTH, 8: counter, datain and step width in bits.
- MIN, 0: lower count bound, inclusive.
- MAX, 2**WIDTH-1: upper count bound, inclusive. Requires MIN < MAX <= 2**WIDTH-1.
- RST_VAL, MIN: value loaded on reset. Requires MIN <= RST_VAL <= MAX.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_en  in  1  load datain (clamped) into counter.
- en  in  1  count enable.
- updwn  in  1  1 = count up, 0 = count down.
- sat_mode  in  1  1 = saturate at bounds, 0 = wrap within [MIN, MAX].
- step  in  WIDTH  increment/decrement amount per enabled cycle.
- datain  in  WIDTH  load value.
- clr_ovf  in  1  clears the sticky ovf flag.
- dataout  out  WIDTH  registered count value.
- tc  out  1  registered terminal-count pulse.
- ovf  out  1  registered sticky overflow flag.

Behaviour:
- Reset (rst=1 at clk edge): dataout=RST_VAL, tc=0, ovf=0. Reset overrides all other inputs, including mid-count.
- Priority per edge: rst > ld_en > en. When ld_en=1, en, updwn and step are ignored that cycle.
- Load: dataout <= clamp(datain, MIN, MAX). datain>MAX loads MAX; datain<MIN loads MIN. Load never sets tc or ovf.
- Hold: en=0 and ld_en=0 keep dataout unchanged; tc=0.
- Effective step: s = min(step, MAX-MIN). A larger step is silently limited to MAX-MIN.
- Range R = MAX-MIN+1. Arithmetic is done at WIDTH+1 bits so no intermediate value is lost.
- Up (en=1, updwn=1): n = dataout + s.
  - n <= MAX: dataout <= n.
  - n > MAX is a boundary event. Wrap mode: dataout <= n - R. Saturate mode: dataout <= MAX.
- Down (en=1, updwn=0): n = dataout - s, computed signed.
  - n >= MIN: dataout <= n.
  - n < MIN is a boundary event. Wrap mode: dataout <= n + R. Saturate mode: dataout <= MIN.
- Reaching MAX or MIN exactly is not a boundary event.
- s=0: dataout unchanged, no event.
- tc: 1 for exactly the cycle in which dataout shows the wrapped or saturated value, i.e. set on the same edge as the event; 0 otherwise.
  - In saturate mode, holding at a bound with s>0 and en=1 produces an event every cycle, so tc stays 1.
- ovf: set to 1 on any boundary event and held until clr_ovf=1.
  - If an event and clr_ovf occur in the same cycle, set wins and ovf=1.
  - ovf is cleared by rst.
- Latency: every output reflects inputs sampled at edge k after edge k. There is no combinational input-to-output path.

Optional Feature:
- Macro: COUNTER_UPDN_ASSERT_EN.
- Defined: the module includes concurrent SVA properties on clk, each disabled iff rst:
  - dataout always within [MIN, MAX];
  - ld_en implies dataout == clamp($past(datain)) on the next cycle;
  - en=0 and ld_en=0 imply $stable(dataout);
  - tc implies ovf;
  - rst implies dataout==RST_VAL on the next cycle.
  A failing property raises $error with the property name.
- Undefined: no assertion code is compiled; RTL behaviour is identical.

Test Plan:
(WIDTH=8, MIN=10, MAX=200, RST_VAL=10 unless noted)
- rst=1 for 2 cycles with ld_en=1, datain=99 -> dataout=10, tc=0, ovf=0; load ignored.
- Load 63, then en=1, updwn=1, step=1, sat_mode=0 for 100 cycles -> dataout=163, tc never 1, ovf=0.
- Load 198, up, step=5, sat_mode=0 -> dataout=12 next cycle, tc=1 for one cycle, ovf=1. Then clr_ovf=1 -> ovf=0.
- Load 12, down, step=5, sat_mode=1 -> dataout=10, tc=1; following cycle dataout=10, tc=1 again. With sat_mode=0 from 12: dataout=198, tc=1.
- Load datain=255 -> 200; load datain=3 -> 10; ld_en=1 with en=1, step=7 -> load value wins. step=250 from 10, up, wrap -> s=190 limited, dataout=200, no event.
- Mid-count rst=1 while en=1 -> dataout=10 next edge. Event coinciding with clr_ovf=1 -> ovf=1. Default params, step=1, wrap from 255 -> 0, tc=1.
